// File: rtl/logic_unit_pipe_pkg.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe_pkg
//   Shared definitions for the registered bitwise logic unit.
//   - OP_W          : width of the operation select field
//   - OP_AND..OP_PASS: 3-bit operation encodings
//   - RED_W         : number of reduction flags carried next to the result
//                     when LOGIC_UNIT_REDUCE_EN is defined
// ---------------------------------------------------------------------------
package logic_unit_pipe_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
    localparam logic [OP_W-1:0] OP_ANDN = 3'd6;  // a & ~b
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;  // a

    // zero, ones, parity
    localparam int RED_W = 3;

endpackage

// File: rtl/skid_buffer.sv
// ---------------------------------------------------------------------------
// skid_buffer
//   Two-entry valid/ready register stage: a main register that drives the
//   output and a skid register that absorbs one extra item when the output
//   stalls. in_ready depends only on flop state, so there is no
//   combinational path from out_ready to in_ready.
//
//   Parameters: DW - data width
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     in_data/in_valid    upstream item and its valid
//     in_ready            buffer can take an item this cycle
//     out_data/out_valid  head item (main register) and its valid
//     out_ready           downstream takes the head item this cycle
//
//   Handshake: an item moves across an interface at a rising edge where
//   valid and ready are both high. A producer holding valid keeps its data
//   stable until that edge; out_data never changes while out_valid=1 and
//   out_ready=0.
// ---------------------------------------------------------------------------
module skid_buffer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    logic [DW-1:0] main_data;
    logic          main_valid;
    logic [DW-1:0] skid_data;
    logic          skid_valid;

    assign in_ready  = ~skid_valid;
    assign out_data  = main_data;
    assign out_valid = main_valid;

    // skid_valid implies main_valid, so the skid branch never has to
    // consider an empty main register, and no input is accepted there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data  <= '0;
            main_valid <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else begin
            if (skid_valid) begin
                if (out_ready) begin
                    main_data  <= skid_data;
                    skid_valid <= 1'b0;
                end
            end else if (in_valid) begin
                if (!main_valid || out_ready) begin
                    // main empty or draining: reload it, stays valid
                    main_data  <= in_data;
                    main_valid <= 1'b1;
                end else begin
                    // main stalled: park the new item behind it
                    skid_data  <= in_data;
                    skid_valid <= 1'b1;
                end
            end else if (out_ready) begin
                main_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe
//   Registered bitwise logic unit. Combines a and b with the operation
//   selected by op and delivers the result one cycle later through a
//   2-entry valid/ready skid buffer (bubble-free under back-pressure).
//
//   Parameters: WIDTH - operand/result width (1..64)
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     a, b, op        operands and operation, sampled on input transfer
//     in_valid        operands valid this cycle
//     in_ready        unit can accept this cycle
//     out, out_valid  registered result and its valid
//     out_ready       downstream takes out this cycle
//     out_zero        result is all zeros   (LOGIC_UNIT_REDUCE_EN)
//     out_ones        result is all ones    (LOGIC_UNIT_REDUCE_EN)
//     out_parity      XOR-reduction of out  (LOGIC_UNIT_REDUCE_EN)
//
//   Build option LOGIC_UNIT_REDUCE_EN: when defined, the three reduction
//   flags travel through the buffer with the data so they stay aligned with
//   out; when undefined they are tied to 0 and nothing extra is stored.
//
//   Handshake: a transfer happens at a rising edge where valid and ready
//   are both high, on either side; held results are never altered by
//   input changes while stalled.
// ---------------------------------------------------------------------------
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity
);

    logic [WIDTH-1:0] result;

    always_comb begin
        result = a;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_XNOR: result = ~(a ^ b);
            OP_ANDN: result = a & ~b;
            default: result = a;  // OP_PASS
        endcase
    end

`ifdef LOGIC_UNIT_REDUCE_EN
    localparam int DW = WIDTH + RED_W;

    logic [DW-1:0] sb_in;
    logic [DW-1:0] sb_out;

    // Flags are packed above the data so reset (all zeros) clears them too.
    assign sb_in = {^result, &result, ~|result, result};
    assign {out_parity, out_ones, out_zero, out} = sb_out;
`else
    localparam int DW = WIDTH;

    logic [DW-1:0] sb_in;
    logic [DW-1:0] sb_out;

    assign sb_in      = result;
    assign out        = sb_out;
    assign out_zero   = 1'b0;
    assign out_ones   = 1'b0;
    assign out_parity = 1'b0;
`endif

    skid_buffer #(
        .DW(DW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (sb_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (sb_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_pipe
//   Self-checking bench for logic_unit_pipe at WIDTH=4. The reference model
//   treats the unit as a 2-deep FIFO of results, each result computed bit by
//   bit from a per-op truth table.
// ---------------------------------------------------------------------------
module tb_logic_unit_pipe;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out;
    logic         out_valid;
    logic         out_ready;
    logic         out_zero;
    logic         out_ones;
    logic         out_parity;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    logic [3:0] tt [8];

    logic [W-1:0] seq_a   [3];
    logic [W-1:0] seq_b   [3];
    logic [W-1:0] seq_out [3];
    logic [W-1:0] sweep_out [8];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .op         (op),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_zero   (out_zero),
        .out_ones   (out_ones),
        .out_parity (out_parity)
    );

    // ---------------- reference model ----------------
    // tt[op] bit index {a_bit,b_bit} gives the result bit.
    function automatic logic [W-1:0] ref_op(input logic [2:0] o,
                                            input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        logic [W-1:0] r;
        logic [3:0]   row;
        r   = '0;
        row = tt[o];
        for (int i = 0; i < W; i++) begin
            r[i] = row[{x[i], y[i]}];
        end
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [W-1:0] h;
        check({tag, "_out_valid"}, 64'(out_valid), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            h = exp_q[0];
            check({tag, "_out"}, 64'(out), 64'(h));
`ifdef LOGIC_UNIT_REDUCE_EN
            check({tag, "_zero"},   64'(out_zero),   64'(h == '0));
            check({tag, "_ones"},   64'(out_ones),   64'(h == '1));
            check({tag, "_parity"}, 64'(out_parity), 64'(^h));
`endif
        end
`ifndef LOGIC_UNIT_REDUCE_EN
        check({tag, "_flags_off"}, 64'({out_zero, out_ones, out_parity}), 64'(0));
`endif
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge; drives one cycle and checks after
    // the next edge.
    task automatic cycle(input string tag, input logic iv, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input logic [2:0] iop, input logic ordy);
        logic acc;
        logic take;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        op        = iop;
        out_ready = ordy;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'(exp_q.size() < 2));
        acc  = iv && (exp_q.size() < 2);
        take = ordy && (exp_q.size() > 0);
        @(posedge clk);
        if (take) void'(exp_q.pop_front());
        if (acc)  exp_q.push_back(ref_op(iop, ia, ib));
        #1;
        check_outputs(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3; i++) cycle(tag, 1'b0, '0, '0, 3'd0, 1'b1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
        tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0100; tt[7] = 4'b1100;

        seq_a[0] = 4'b1111; seq_b[0] = 4'b0101; seq_out[0] = 4'b0101;
        seq_a[1] = 4'b0110; seq_b[1] = 4'b1100; seq_out[1] = 4'b1110;
        seq_a[2] = 4'b1110; seq_b[2] = 4'b0111; seq_out[2] = 4'b1001;

        sweep_out[0] = 4'b1000; sweep_out[1] = 4'b1110; sweep_out[2] = 4'b0110;
        sweep_out[3] = 4'b0111; sweep_out[4] = 4'b0001; sweep_out[5] = 4'b1001;
        sweep_out[6] = 4'b0100; sweep_out[7] = 4'b1100;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;
        #2;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_in_ready",  64'(in_ready),  64'(1));
        check("reset_out",       64'(out),       64'(0));
        check("reset_flags",     64'({out_zero, out_ones, out_parity}), 64'(0));
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // basic sequence, out_ready high
        for (int i = 0; i < 3; i++) begin
            cycle("seq", 1'b1, seq_a[i], seq_b[i], 3'(i), 1'b1);
            check("seq_const_out", 64'(out), 64'(seq_out[i]));
        end
        drain("seq_drain");

        // op sweep
        for (int i = 0; i < 8; i++) begin
            cycle("sweep", 1'b1, 4'b1100, 4'b1010, 3'(i), 1'b1);
            check("sweep_const_out", 64'(out), 64'(sweep_out[i]));
        end
        drain("sweep_drain");

        // back-pressure: 3 offered, 2 accepted
        cycle("bp", 1'b1, 4'b1111, 4'b0011, 3'd0, 1'b0);
        cycle("bp", 1'b1, 4'b1010, 4'b0101, 3'd1, 1'b0);
        cycle("bp", 1'b1, 4'b1111, 4'b1111, 3'd2, 1'b0);
        check("bp_in_ready_low", 64'(in_ready), 64'(0));
        check("bp_hold_first",   64'(out),      64'(4'b0011));
        cycle("bp_rel", 1'b0, '0, '0, 3'd0, 1'b1);
        check("bp_second", 64'(out), 64'(4'b1111));
        check("bp_in_ready_back", 64'(in_ready), 64'(1));
        drain("bp_drain");

        // reduction flags
        cycle("red", 1'b1, 4'b0000, 4'b1111, 3'd0, 1'b1);
        cycle("red", 1'b1, 4'b0000, 4'b1111, 3'd4, 1'b1);
        check("red_nor_out", 64'(out), 64'(0));
        cycle("red", 1'b1, 4'b0111, 4'b0000, 3'd7, 1'b1);
`ifdef LOGIC_UNIT_REDUCE_EN
        check("red_pass_parity", 64'(out_parity), 64'(1));
`else
        check("red_pass_parity_off", 64'(out_parity), 64'(0));
`endif
        drain("red_drain");

        // random traffic with random back-pressure, op changing while stalled
        for (int i = 0; i < 400; i++) begin
            cycle("rnd", 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
        end
        drain("rnd_drain");

        // reset while skid is full
        cycle("rst_fill", 1'b1, 4'b1100, 4'b1010, 3'd2, 1'b0);
        cycle("rst_fill", 1'b1, 4'b1100, 4'b1010, 3'd1, 1'b0);
        check("rst_fill_in_ready", 64'(in_ready), 64'(0));
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        check("rst_async_out_valid", 64'(out_valid), 64'(0));
        check("rst_async_in_ready",  64'(in_ready),  64'(1));
        check("rst_async_out",       64'(out),       64'(0));
        check("rst_async_flags",     64'({out_zero, out_ones, out_parity}), 64'(0));
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_no_xfer", 64'(out_valid), 64'(0));
        rst = 1'b0;
        cycle("post_rst", 1'b1, 4'b0110, 4'b0011, 3'd6, 1'b1);
        check("post_rst_const", 64'(out), 64'(4'b0100));
        drain("post_rst_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
